// File: rtl/axi_read_vector.sv
// axi_read_vector: fetches VLEN 32-bit words in one AXI4 INCR read burst,
// retrying errored or wrong-length bursts up to MAX_RETRY times.
// Ports: clk/rst (sync, active-high), start request; AR channel
// (ar_addr/size/len/burst constant, ar_valid/ar_ready); R channel
// (r_data/resp/last/valid, r_ready); vec + vec_valid pulse, busy, error.
module axi_read_vector #(
  parameter int unsigned VLEN       = 1,
  parameter logic [31:0] START_ADDR = 32'hA000_0000,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [31:0]          ar_addr,
  output logic [2:0]           ar_size,
  output logic [7:0]           ar_len,
  output logic [1:0]           ar_burst,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  input  logic [31:0]          r_data,
  input  logic [1:0]           r_resp,
  input  logic                 r_last,
  input  logic                 r_valid,
  output logic                 r_ready,
  output logic [32*VLEN-1:0]   vec,
  output logic                 vec_valid,
  output logic                 busy,
  output logic                 error
);

  localparam int CW = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_DRAIN, S_CHECK
  } state_t;

  state_t              state_q, state_d;
  logic                ar_valid_q, ar_valid_d;
  logic                r_ready_q, r_ready_d;
  logic [32*VLEN-1:0]  vec_q, vec_d;
  logic [32*VLEN-1:0]  shadow_q, shadow_d;
  logic                vec_valid_q, vec_valid_d;
  logic                busy_q, busy_d;
  logic                error_q, error_d;
  logic [CW-1:0]       beat_cnt_q, beat_cnt_d;
  logic [RW-1:0]       retry_cnt_q, retry_cnt_d;
  logic                err_seen_q, err_seen_d;
  logic                len_err_q, len_err_d;

  logic beat;
  logic beat_last;
  logic unused_resp0;

  assign ar_addr   = START_ADDR;
  assign ar_size   = 3'b010;
  assign ar_len    = 8'(VLEN - 1);
  assign ar_burst  = 2'b01;
  assign ar_valid  = ar_valid_q;
  assign r_ready   = r_ready_q;
  assign vec       = vec_q;
  assign vec_valid = vec_valid_q;
  assign busy      = busy_q;
  assign error     = error_q;

  // Only bit 1 of the response distinguishes an error beat.
  assign unused_resp0 = r_resp[0];

  assign beat      = r_valid && r_ready_q;
  assign beat_last = (beat_cnt_q == CW'(VLEN - 1));

  always_comb begin
    state_d     = state_q;
    ar_valid_d  = ar_valid_q;
    r_ready_d   = r_ready_q;
    vec_d       = vec_q;
    shadow_d    = shadow_q;
    vec_valid_d = 1'b0;
    error_d     = error_q;
    beat_cnt_d  = beat_cnt_q;
    retry_cnt_d = retry_cnt_q;
    err_seen_d  = err_seen_q;
    len_err_d   = len_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_ADDR;
          ar_valid_d  = 1'b1;
          error_d     = 1'b0;
          retry_cnt_d = '0;
          beat_cnt_d  = '0;
          err_seen_d  = 1'b0;
          len_err_d   = 1'b0;
        end
      end
      S_ADDR: begin
        if (ar_valid_q && ar_ready) begin
          state_d    = S_DATA;
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
        end
      end
      S_DATA: begin
        if (beat) begin
          shadow_d[32*beat_cnt_q +: 32] = r_data;
          err_seen_d = err_seen_q | r_resp[1];
          beat_cnt_d = beat_cnt_q + CW'(1);
          if (beat_last) begin
            if (r_last) begin
              state_d   = S_CHECK;
              r_ready_d = 1'b0;
            end else begin
              // Slave keeps going past VLEN: swallow the rest.
              len_err_d = 1'b1;
              state_d   = S_DRAIN;
            end
          end else if (r_last) begin
            len_err_d = 1'b1;
            state_d   = S_CHECK;
            r_ready_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (beat && r_last) begin
          state_d   = S_CHECK;
          r_ready_d = 1'b0;
        end
      end
      S_CHECK: begin
        if (!err_seen_q && !len_err_q) begin
          vec_d       = shadow_q;
          vec_valid_d = 1'b1;
          state_d     = S_IDLE;
        end else if (retry_cnt_q < RW'(MAX_RETRY)) begin
          retry_cnt_d = retry_cnt_q + RW'(1);
          beat_cnt_d  = '0;
          err_seen_d  = 1'b0;
          len_err_d   = 1'b0;
          ar_valid_d  = 1'b1;
          state_d     = S_ADDR;
        end else begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        ar_valid_d = 1'b0;
        r_ready_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      vec_q       <= '0;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      beat_cnt_q  <= '0;
      retry_cnt_q <= '0;
      err_seen_q  <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ar_valid_q  <= ar_valid_d;
      r_ready_q   <= r_ready_d;
      vec_q       <= vec_d;
      vec_valid_q <= vec_valid_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
      beat_cnt_q  <= beat_cnt_d;
      retry_cnt_q <= retry_cnt_d;
      err_seen_q  <= err_seen_d;
      len_err_q   <= len_err_d;
    end
  end

  // Shadow contents are irrelevant until a full burst lands.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

endmodule

// File: tb/tb_axi_read_vector.sv
// tb_axi_read_vector: randomized slave + transaction-level model for
// axi_read_vector with VLEN=4, MAX_RETRY=3.
module tb_axi_read_vector;

  localparam int VLEN = 4;
  localparam int MAXR = 3;
  localparam int NA   = MAXR + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [31:0]         ar_addr;
  logic [2:0]          ar_size;
  logic [7:0]          ar_len;
  logic [1:0]          ar_burst;
  logic                ar_valid;
  logic                ar_ready = 1'b0;
  logic [31:0]         r_data = '0;
  logic [1:0]          r_resp = '0;
  logic                r_last = 1'b0;
  logic                r_valid = 1'b0;
  logic                r_ready;
  logic [32*VLEN-1:0]  vec;
  logic                vec_valid;
  logic                busy;
  logic                error;

  int checks = 0;
  int errors = 0;

  logic [32*VLEN-1:0] model_vec = '0;
  logic               model_err = 1'b0;
  logic [31:0]        bw [0:15];

  int cyc = 0;
  int ar_hs = 0;
  int vv_cnt = 0;
  int start_cyc = 0;
  int vv_cyc = 0;

  axi_read_vector #(
    .VLEN(VLEN),
    .START_ADDR(32'hA000_0000),
    .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .ar_addr(ar_addr), .ar_size(ar_size), .ar_len(ar_len),
    .ar_burst(ar_burst), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_last(r_last),
    .r_valid(r_valid), .r_ready(r_ready),
    .vec(vec), .vec_valid(vec_valid), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change 1 time unit after posedge, so at negedge everything
  // describes what the next posedge will sample.
  always @(negedge clk) begin
    if (ar_valid && ar_ready) ar_hs++;
    if (vec_valid) begin
      vv_cnt++;
      vv_cyc = cyc;
    end
    if (start && !busy && !rst) start_cyc = cyc;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input int nb, input int eb, input int dly,
                           input bit gaps, input bit bstart,
                           input bit fixed, input string nm);
    int n;
    bit stable;
    bit rr_ok;
    n = 0;
    while (!ar_valid && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (ar_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s ar_wait: ar_valid=%b required 1", nm, ar_valid);
      return;
    end
    stable = 1'b1;
    for (int d = 0; d < dly; d++) begin
      ar_ready = 1'b0;
      if (bstart) start = 1'b1;
      step();
      if (ar_valid !== 1'b1) stable = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL %s ar_hold: ar_valid dropped before handshake", nm);
    end
    ar_ready = 1'b1;
    step();
    ar_ready = 1'b0;
    rr_ok = 1'b1;
    for (int b = 0; b < nb; b++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        r_valid = 1'b0;
        step();
      end
      bw[b]   = fixed ? 32'h11 * (b + 1) : $urandom;
      r_data  = bw[b];
      r_resp  = (b == eb) ? 2'b10 : {1'b0, 1'($urandom_range(0, 1))};
      r_last  = (b == nb - 1);
      r_valid = 1'b1;
      if (r_ready !== 1'b1) rr_ok = 1'b0;
      step();
    end
    r_valid = 1'b0;
    r_last  = 1'b0;
    r_resp  = 2'b00;
    checks++;
    if (!rr_ok) begin
      errors++;
      $display("FAIL %s r_ready: low while beats offered, required 1", nm);
    end
  endtask

  // Transaction-level model: attempt k is good only when it carries
  // exactly VLEN beats and no error response; at most MAXR+1 attempts.
  task automatic transaction(input int nb [NA], input int eb [NA],
                             input int dly, input bit gaps,
                             input bit bstart, input bit fixed,
                             input string nm);
    int hs0, vv0, att, n;
    bit clean;
    hs0 = ar_hs;
    vv0 = vv_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    clean = 1'b0;
    att = 0;
    for (int k = 0; k < NA; k++) begin
      att++;
      run_burst(nb[k], eb[k], dly, gaps, bstart, fixed, nm);
      clean = (nb[k] == VLEN) && (eb[k] < 0);
      if (clean) begin
        for (int i = 0; i < VLEN; i++) model_vec[32*i +: 32] = bw[i];
        break;
      end
    end
    model_err = !clean;
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: busy=%b required 0", nm, busy);
    end
    checks++;
    if (ar_hs - hs0 !== att) begin
      errors++;
      $display("FAIL %s ar_count: %0d required %0d", nm, ar_hs - hs0, att);
    end
    checks++;
    if (vv_cnt - vv0 !== int'(clean)) begin
      errors++;
      $display("FAIL %s vv_count: %0d required %0d", nm, vv_cnt - vv0,
               int'(clean));
    end
    checks++;
    if (error !== model_err) begin
      errors++;
      $display("FAIL %s error: %b required %b", nm, error, model_err);
    end
    checks++;
    if (vec !== model_vec) begin
      errors++;
      $display("FAIL %s vec: %h required %h", nm, vec, model_vec);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    step();
    step();
    rst = 1'b0;
    start = 1'b0;
    step();
    checks++;
    if ({ar_valid, r_ready, vec_valid, busy, error} !== 5'b0) begin
      errors++;
      $display("FAIL reset ctl: %b required 00000",
               {ar_valid, r_ready, vec_valid, busy, error});
    end
    checks++;
    if (vec !== '0) begin
      errors++;
      $display("FAIL reset vec: %h required 0", vec);
    end
    checks++;
    if ({ar_addr, ar_size, ar_len, ar_burst} !==
        {32'hA000_0000, 3'b010, 8'd3, 2'b01}) begin
      errors++;
      $display("FAIL reset ar_const: addr=%h size=%b len=%0d burst=%b",
               ar_addr, ar_size, ar_len, ar_burst);
    end
  endtask

  task automatic test_clean_latency();
    int nb [NA] = '{4, 4, 4, 4};
    int eb [NA] = '{-1, -1, -1, -1};
    transaction(nb, eb, 0, 1'b0, 1'b0, 1'b1, "clean");
    checks++;
    if (vec !== 128'h00000044_00000033_00000022_00000011) begin
      errors++;
      $display("FAIL clean vec_const: %h required 44/33/22/11", vec);
    end
    // Pulse asserted VLEN+2 edges after start; seen one cycle later.
    checks++;
    if (vv_cyc - start_cyc !== VLEN + 3) begin
      errors++;
      $display("FAIL clean latency: %0d required %0d",
               vv_cyc - start_cyc, VLEN + 3);
    end
  endtask

  task automatic test_stall();
    int nb [NA] = '{4, 4, 4, 4};
    int eb [NA] = '{-1, -1, -1, -1};
    transaction(nb, eb, 5, 1'b1, 1'b1, 1'b0, "stall");
  endtask

  task automatic test_retry_once();
    int nb [NA] = '{4, 4, 4, 4};
    int eb [NA] = '{2, -1, -1, -1};
    transaction(nb, eb, 1, 1'b0, 1'b0, 1'b0, "retry1");
  endtask

  task automatic test_retry_exhaust();
    int nb [NA] = '{4, 4, 4, 4};
    int eb [NA];
    for (int k = 0; k < NA; k++) eb[k] = $urandom_range(0, VLEN - 1);
    transaction(nb, eb, 0, 1'b1, 1'b0, 1'b0, "exhaust");
  endtask

  task automatic test_length();
    int nb [NA] = '{2, 5, 4, 4};
    int eb [NA] = '{-1, -1, -1, -1};
    transaction(nb, eb, 0, 1'b0, 1'b0, 1'b0, "length");
  endtask

  task automatic test_reset_mid_burst();
    start = 1'b1;
    step();
    start = 1'b0;
    ar_ready = 1'b1;
    step();
    ar_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      r_data = $urandom;
      r_valid = 1'b1;
      step();
    end
    r_data = $urandom;
    rst = 1'b1;
    step();
    rst = 1'b0;
    r_valid = 1'b0;
    model_vec = '0;
    model_err = 1'b0;
    checks++;
    if ({ar_valid, r_ready, vec_valid, busy, error} !== 5'b0) begin
      errors++;
      $display("FAIL midrst ctl: %b required 00000",
               {ar_valid, r_ready, vec_valid, busy, error});
    end
    checks++;
    if (vec !== '0) begin
      errors++;
      $display("FAIL midrst vec: %h required 0", vec);
    end
    step();
  endtask

  task automatic test_random();
    int nb [NA];
    int eb [NA];
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < NA; k++) begin
        nb[k] = $urandom_range(0, 3) == 0 ? $urandom_range(1, 6) : VLEN;
        eb[k] = $urandom_range(0, 2) == 0 ?
                int'($urandom_range(0, nb[k] - 1)) : -1;
      end
      transaction(nb, eb, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_clean_latency();
    test_stall();
    test_retry_once();
    test_retry_exhaust();
    test_length();
    test_reset_mid_burst();
    test_clean_latency();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_read_vector.md
Name: axi_read_vector

Overview:
- AXI4 read-channel master that fetches a VLEN-element vector of 32-bit words from memory in one INCR burst.
- Presents the vector as a flat bus to the NN compute stages.
- Upstream counterpart of the vector-to-AXI write stage: loads operands that the write stage later stores back.
- Retries the burst on read errors, up to a bounded count.

Parameters:
- VLEN, 1: vector length in 32-bit words; legal range 1..256.
- START_ADDR, 'hA000_0000: byte address of element 0.
- MAX_RETRY, 3: burst re-issues allowed after an errored burst before giving up.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request a read; sampled only in IDLE.
- ar_addr  out  32  constant START_ADDR.
- ar_size  out  3  constant 3'b010 (4 bytes/beat).
- ar_len  out  8  constant VLEN-1 (AXI beats-minus-one encoding).
- ar_burst  out  2  constant 2'b01 (INCR).
- ar_valid  out  1  address valid.
- ar_ready  in  1  address accepted.
- r_data  in  32  read beat data.
- r_resp  in  2  beat response; bit 1 set = SLVERR/DECERR.
- r_last  in  1  last beat of burst.
- r_valid  in  1  beat valid.
- r_ready  out  1  beat accept.
- vec  out  32*VLEN  last successfully read vector; element i at [32*i +: 32].
- vec_valid  out  1  one-cycle pulse: vec just updated.
- busy  out  1  high whenever state != IDLE.
- error  out  1  sticky fail flag; cleared by rst or an accepted start.

Behaviour:
- Reset (rst high at posedge): state=IDLE; ar_valid=0, r_ready=0, vec=0, vec_valid=0, busy=0, error=0; beat and retry counters=0; shadow buffer contents don't-care. Reset mid-burst abandons the transaction with no drain.
- States: IDLE, ADDR, DATA, DRAIN, CHECK.
- IDLE:
  - start=1 → ADDR; clear error, retry_cnt, beat_cnt, err_seen, len_err.
  - start in any other state is ignored.
- ADDR:
  - ar_valid=1, held until a cycle with ar_valid&&ar_ready.
  - On that handshake edge: ar_valid←0, → DATA.
  - ar_valid never drops before the handshake.
- DATA:
  - r_ready=1.
  - Each beat (r_valid&&r_ready): shadow[beat_cnt]←r_data; err_seen|=r_resp[1]; beat_cnt++.
  - Beat with beat_cnt==VLEN-1 and r_last=1 → CHECK.
  - Beat with beat_cnt==VLEN-1 and r_last=0 → len_err=1, → DRAIN.
  - Beat with r_last=1 and beat_cnt<VLEN-1 (short burst) → len_err=1, → CHECK.
- DRAIN: r_ready=1; discard beats until one with r_last=1, then → CHECK.
- CHECK (exactly one cycle, r_ready=0):
  - No error (err_seen=0 and len_err=0): vec←shadow, vec_valid=1 for one cycle, → IDLE.
  - Error and retry_cnt<MAX_RETRY: retry_cnt++; clear beat_cnt, err_seen, len_err; → ADDR (new burst).
  - Error and retry_cnt==MAX_RETRY: error←1, vec unchanged, no vec_valid, → IDLE.
- vec changes only on a clean CHECK; a partial or errored burst never reaches vec.
- Latency (ar_ready and r_valid continuously high):
  - start sampled at edge E0; ar handshake at E1; beats at E2..E(VLEN+1); CHECK→IDLE at E(VLEN+2).
  - vec_valid high in the cycle after E(VLEN+2); no wait cycles inserted by the block.
- A VLEN=1 burst has a single beat that must carry r_last=1.
- Simultaneous start and rst: rst wins.

Test Plan:
- VLEN=4, ar_ready=1, slave returns 0x11,0x22,0x33,0x44 back-to-back with r_last on beat 3 → ar_len=3, vec={0x44,0x33,0x22,0x11}, vec_valid pulse exactly 6 edges after start edge, error=0.
- ar_ready held low 5 cycles, r_valid toggling 1/0 → ar_valid stable until handshake, all 4 beats captured correctly, single vec_valid.
- Beat 2 with r_resp=2'b10 on first burst, second burst clean → one retry observed (two ar handshakes), vec from second burst, error=0.
- Every burst returns SLVERR, MAX_RETRY=3 → exactly 4 ar handshakes, error=1, vec still holds previous value, no vec_valid.
- r_last asserted on beat 1 of a VLEN=4 burst, and separately withheld until beat 5 (DRAIN consumes the extra beat) → each treated as error and retried.
- rst asserted during DATA at beat 2 → all outputs at reset values next cycle; a new start then completes normally; start while busy has no effect.
